// File: rtl/mcpu_defs_pkg.sv
// mcpu_defs: shared encodings for the multi-cycle RV32I control sequencer
package mcpu_defs;
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXR, S_EXI, S_WBA, S_MA, S_MRD, S_WBL, S_MWR, S_BR, S_JAL, S_JALR, S_WBU
  } state_t;
  typedef enum logic [1:0] {M_ADD, M_SUB, M_R, M_I} alu_mode_t;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;
  localparam logic [1:0] M2R_IMM = 2'd3;
  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_L     = 5'b00000;
  localparam logic [4:0] OP_S     = 5'b01000;
  localparam logic [4:0] OP_B     = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
endpackage

// File: rtl/mcpu_ctrl_fsm_alu_ctrl_dec.sv
// alu_ctrl_dec: maps (mode, Fun3, Fun7) to the ALU_Control code
module alu_ctrl_dec
  import mcpu_defs::*;
(
  input  alu_mode_t  mode_i,
  input  logic [2:0] fun3_i,
  input  logic       fun7_i,
  output logic [3:0] alu_ctrl_o
);
  logic       alt;
  logic       r_ok;
  logic [3:0] op;
  // Fun7 selects sub only for R-type; it selects sra for both R and I shifts
  assign alt  = fun7_i && (fun3_i == 3'b101 || (mode_i == M_R && fun3_i == 3'b000));
  assign r_ok = !fun7_i || fun3_i == 3'b000 || fun3_i == 3'b101;
  // base operation from Fun3
  always_comb begin
    op = ALU_ADD;
    case (fun3_i)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
  end
  assign alu_ctrl_o = mode_i == M_SUB ? ALU_SUB :
                      (mode_i == M_ADD || (mode_i == M_R && !r_ok)) ? ALU_ADD : op;
endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: multi-cycle RV32I control sequencer with memory wait and timeout
module mcpu_ctrl_fsm
  import mcpu_defs::*;
#(
  parameter bit          MIO_WAIT = 1'b1,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       Zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemRW,
  output logic       RegWrite,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [3:0] ALU_Control,
  output logic [2:0] ImmSel,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic       Bus_err,
  output logic [3:0] state
);
  localparam int CW = 16;
  state_t      state_q, state_d;
  logic [CW-1:0] wait_q;
  alu_mode_t   mode;
  logic        rdy, mem_st, tmo;
  assign rdy    = !MIO_WAIT || MIO_ready;
  assign mem_st = state_q inside {S_IF, S_MRD, S_MWR};
  assign tmo    = TIMEOUT != 0 && mem_st && !rdy && 32'(wait_q) + 32'd1 == TIMEOUT;
  assign state  = state_q;
  alu_ctrl_dec u_dec (
    .mode_i     (mode),
    .fun3_i     (Fun3),
    .fun7_i     (Fun7),
    .alu_ctrl_o (ALU_Control)
  );
  // state register and saturating wait counter; a timeout restarts the count even when staying in IF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_d != state_q || tmo) ? '0 :
                 (mem_st && !rdy && wait_q != '1) ? wait_q + CW'(1) : wait_q;
    end
  end
  // next state and Moore/Mealy outputs; enables are forced low while rst is high
  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRd    = 1'b0;
    MemRW    = 1'b0;
    RegWrite = 1'b0;
    ALUSrc_A = 2'd0;
    ALUSrc_B = 2'd0;
    mode     = M_ADD;
    ImmSel   = IMM_U;
    MemtoReg = M2R_ALU;
    PCSource = 2'd0;
    Illegal  = 1'b0;
    Bus_err  = tmo;
    case (state_q)
      S_IF: begin
        MemRd    = !tmo;
        ALUSrc_B = 2'd2;
        IRWrite  = rdy;
        PCWrite  = rdy;
        state_d  = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrc_A = 2'd2;
        ALUSrc_B = 2'd1;
        case (OPcode[1:0] == 2'b11 ? OPcode[6:2] : 5'b11111)
          OP_R:     state_d = S_EXR;
          OP_I:     begin ImmSel = IMM_I; state_d = S_EXI; end
          OP_L:     begin ImmSel = IMM_I; state_d = S_MA; end
          OP_S:     begin ImmSel = IMM_S; state_d = S_MA; end
          OP_B:     begin ImmSel = IMM_B; state_d = S_BR; end
          OP_JAL:   begin ImmSel = IMM_J; state_d = S_JAL; end
          OP_JALR:  begin ImmSel = IMM_I; state_d = S_JALR; end
          OP_LUI:   state_d = S_WBU;
          OP_AUIPC: state_d = S_WBA;
          default:  begin Illegal = 1'b1; state_d = S_IF; end
        endcase
      end
      S_EXR: begin
        ALUSrc_A = 2'd1;
        mode     = M_R;
        state_d  = S_WBA;
      end
      S_EXI: begin
        ALUSrc_A = 2'd1;
        ALUSrc_B = 2'd1;
        ImmSel   = IMM_I;
        mode     = M_I;
        state_d  = S_WBA;
      end
      S_WBA: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_MA: begin
        ALUSrc_A = 2'd1;
        ALUSrc_B = 2'd1;
        ImmSel   = OPcode[5] ? IMM_S : IMM_I;
        state_d  = OPcode[5] ? S_MWR : S_MRD;
      end
      S_MRD: begin
        MemRd   = !tmo;
        IorD    = 1'b1;
        state_d = tmo ? S_IF : rdy ? S_WBL : S_MRD;
      end
      S_WBL: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
        state_d  = S_IF;
      end
      S_MWR: begin
        MemRW   = !tmo;
        IorD    = 1'b1;
        state_d = (tmo || rdy) ? S_IF : S_MWR;
      end
      S_BR: begin
        ALUSrc_A = 2'd1;
        mode     = M_SUB;
        PCSource = 2'd1;
        PCWrite  = (Fun3 == 3'b000 && Zero) || (Fun3 == 3'b001 && !Zero);
        state_d  = S_IF;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'd1;
        RegWrite = 1'b1;
        MemtoReg = M2R_PC;
        state_d  = S_IF;
      end
      S_JALR: begin
        ALUSrc_A = 2'd1;
        ALUSrc_B = 2'd1;
        ImmSel   = IMM_I;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = M2R_PC;
        state_d  = S_IF;
      end
      S_WBU: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_IMM;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRd    = 1'b0;
      MemRW    = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
      Bus_err  = 1'b0;
    end
  end
endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// tb_mcpu_ctrl_fsm: instruction-level model expands each instruction into expected per-cycle outputs
module tb_mcpu_ctrl_fsm;
  import mcpu_defs::*;
  localparam int TO = 4;
  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, iord, mrd, mrw, rw;
    logic [1:0] asa, asb;
    logic [3:0] aluc;
    logic [2:0] imm;
    logic [1:0] m2r, pcs;
    logic ill, berr;
  } exp_t;
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z, rdy, r;
  } in_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] OPcode = '0;
  logic [2:0] Fun3 = '0;
  logic Fun7 = 1'b0, Zero = 1'b0, MIO_ready = 1'b0;
  logic PCWrite, IRWrite, IorD, MemRd, MemRW, RegWrite, Illegal, Bus_err;
  logic [1:0] ALUSrc_A, ALUSrc_B, MemtoReg, PCSource;
  logic [3:0] ALU_Control, state;
  logic [2:0] ImmSel;
  mcpu_ctrl_fsm #(.MIO_WAIT(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7), .Zero(Zero),
    .MIO_ready(MIO_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemRd(MemRd), .MemRW(MemRW), .RegWrite(RegWrite), .ALUSrc_A(ALUSrc_A),
    .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .ImmSel(ImmSel),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .Illegal(Illegal), .Bus_err(Bus_err),
    .state(state)
  );
  always #5 clk = ~clk;
  exp_t  exp_q[$];
  in_t   in_q[$];
  string nm_q[$];
  exp_t  cur, act;
  string cur_n;
  bit    chk = 1'b0;
  int    tests = 0, fails = 0;
  assign act = {state, PCWrite, IRWrite, IorD, MemRd, MemRW, RegWrite, ALUSrc_A, ALUSrc_B,
                ALU_Control, ImmSel, MemtoReg, PCSource, Illegal, Bus_err};
  // per-cycle comparison of DUT outputs against the model, away from the rising edge
  always @(negedge clk) begin
    if (chk) begin
      tests++;
      if (act !== cur) begin
        fails++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", cur_n, act, act.st, cur, cur.st);
      end
    end
  end
  task automatic pin(input string n, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL pin %s: got %0d expected %0d", n, got, want);
    end
  endtask
  function automatic exp_t dflt(input state_t s);
    exp_t e = '0;
    e.st = s;
    e.aluc = 4'b0010;
    return e;
  endfunction
  task automatic cyc(input string n, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input logic rdy, input logic r, input exp_t e);
    in_q.push_back({op, f3, f7, z, rdy, r});
    exp_q.push_back(e);
    nm_q.push_back(n);
  endtask
  task automatic rst_cyc(input string n);
    exp_t e = dflt(S_IF);
    e.asb = 2'd2;
    cyc(n, 7'b0, 3'b0, 1'b0, 1'b0, 1'b1, 1'b1, e);
  endtask
  // fetch: w cycles of wait, the TO-th wait is a timeout with no fetch
  task automatic fetch(input string n, input logic [6:0] op, input logic [2:0] f3, input logic f7, input int w);
    exp_t e;
    for (int i = 0; i < w && i < TO; i++) begin
      e = dflt(S_IF);
      e.asb = 2'd2;
      e.mrd = (i != TO - 1);
      e.berr = (i == TO - 1);
      cyc(n, op, f3, f7, 1'b0, 1'b0, 1'b0, e);
    end
    if (w < TO) begin
      e = dflt(S_IF);
      e.asb = 2'd2;
      e.mrd = 1'b1;
      e.pcw = 1'b1;
      e.irw = 1'b1;
      cyc(n, op, f3, f7, 1'b0, 1'b1, 1'b0, e);
    end
  endtask
  task automatic mem(input string n, input logic [6:0] op, input logic [2:0] f3, input state_t st,
                     input int w, input bit full);
    exp_t e;
    for (int i = 0; i < w && i < TO; i++) begin
      e = dflt(st);
      e.iord = 1'b1;
      e.mrd = (st == S_MRD) && (i != TO - 1);
      e.mrw = (st == S_MWR) && (i != TO - 1);
      e.berr = (i == TO - 1);
      cyc(n, op, f3, 1'b0, 1'b0, 1'b0, 1'b0, e);
    end
    if (full && w < TO) begin
      e = dflt(st);
      e.iord = 1'b1;
      e.mrd = (st == S_MRD);
      e.mrw = (st == S_MWR);
      cyc(n, op, f3, 1'b0, 1'b0, 1'b1, 1'b0, e);
    end
  endtask
  task automatic decode(input string n, input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    exp_t e = dflt(S_ID);
    e.asa = 2'd2;
    e.asb = 2'd1;
    case (op)
      7'b0110011, 7'b0110111, 7'b0010111: e.imm = 3'b000;
      7'b0010011, 7'b0000011, 7'b1100111: e.imm = 3'b001;
      7'b0100011: e.imm = 3'b010;
      7'b1100011: e.imm = 3'b011;
      7'b1101111: e.imm = 3'b100;
      default: e.ill = 1'b1;
    endcase
    cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
  endtask
  task automatic ma(input string n, input logic [6:0] op, input logic [2:0] f3, input logic [2:0] imm);
    exp_t e = dflt(S_MA);
    e.asa = 2'd1;
    e.asb = 2'd1;
    e.imm = imm;
    cyc(n, op, f3, 1'b0, 1'b0, 1'b1, 1'b0, e);
  endtask
  // one instruction: fetch, decode, then the class-specific execute/writeback cycles
  task automatic instr(input string n, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [3:0] alu, input logic z, input int w);
    exp_t e;
    fetch(n, op, f3, f7, 0);
    decode(n, op, f3, f7, z);
    e = dflt(S_WBA);
    e.rw = 1'b1;
    case (op)
      7'b0110011: begin
        exp_t x = dflt(S_EXR);
        x.asa = 2'd1;
        x.aluc = alu;
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, x);
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
      end
      7'b0010011: begin
        exp_t x = dflt(S_EXI);
        x.asa = 2'd1;
        x.asb = 2'd1;
        x.imm = 3'b001;
        x.aluc = alu;
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, x);
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
      end
      7'b0010111: cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
      7'b0000011: begin
        ma(n, op, f3, 3'b001);
        mem(n, op, f3, S_MRD, w, 1'b1);
        if (w < TO) begin
          e = dflt(S_WBL);
          e.rw = 1'b1;
          e.m2r = 2'd1;
          cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
        end
      end
      7'b0100011: begin
        ma(n, op, f3, 3'b010);
        mem(n, op, f3, S_MWR, w, 1'b1);
      end
      7'b1100011: begin
        e = dflt(S_BR);
        e.asa = 2'd1;
        e.aluc = 4'b0110;
        e.pcs = 2'd1;
        e.pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
      end
      7'b1101111: begin
        e = dflt(S_JAL);
        e.pcw = 1'b1;
        e.pcs = 2'd1;
        e.rw = 1'b1;
        e.m2r = 2'd2;
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
      end
      7'b1100111: begin
        e = dflt(S_JALR);
        e.asa = 2'd1;
        e.asb = 2'd1;
        e.imm = 3'b001;
        e.pcw = 1'b1;
        e.rw = 1'b1;
        e.m2r = 2'd2;
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
      end
      7'b0110111: begin
        e = dflt(S_WBU);
        e.rw = 1'b1;
        e.m2r = 2'd3;
        cyc(n, op, f3, f7, z, 1'b1, 1'b0, e);
      end
      default: ;
    endcase
  endtask
  initial begin
    int s;
    rst_cyc("reset");
    rst_cyc("reset");
    s = exp_q.size();
    instr("add", 7'b0110011, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    pin("add_len", exp_q.size() - s, 4);
    pin("add_exr_alu", int'(exp_q[s+2].aluc), 2);
    pin("add_wba_rw", int'(exp_q[s+3].rw), 1);
    instr("sub", 7'b0110011, 3'b000, 1'b1, 4'b0110, 1'b0, 0);
    instr("and", 7'b0110011, 3'b111, 1'b0, 4'b0000, 1'b0, 0);
    instr("or", 7'b0110011, 3'b110, 1'b0, 4'b0001, 1'b0, 0);
    instr("sra", 7'b0110011, 3'b101, 1'b1, 4'b1111, 1'b0, 0);
    instr("sll", 7'b0110011, 3'b001, 1'b0, 4'b1110, 1'b0, 0);
    instr("sltu", 7'b0110011, 3'b011, 1'b0, 4'b1001, 1'b0, 0);
    instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 4'b0010, 1'b0, 0);
    instr("srai", 7'b0010011, 3'b101, 1'b1, 4'b1111, 1'b0, 0);
    instr("srli", 7'b0010011, 3'b101, 1'b0, 4'b1101, 1'b0, 0);
    instr("slti", 7'b0010011, 3'b010, 1'b0, 4'b0111, 1'b0, 0);
    instr("xori", 7'b0010011, 3'b100, 1'b0, 4'b1100, 1'b0, 0);
    s = exp_q.size();
    instr("lw_wait3", 7'b0000011, 3'b010, 1'b0, 4'b0010, 1'b0, 3);
    pin("lw_len", exp_q.size() - s, 8);
    pin("lw_c8_rw", int'(exp_q[s+7].rw), 1);
    pin("lw_c8_m2r", int'(exp_q[s+7].m2r), 1);
    s = exp_q.size();
    instr("sw", 7'b0100011, 3'b010, 1'b0, 4'b0010, 1'b0, 0);
    pin("sw_len", exp_q.size() - s, 4);
    s = exp_q.size();
    instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 4'b0110, 1'b1, 0);
    pin("beq_len", exp_q.size() - s, 3);
    pin("beq_pcw", int'(exp_q[s+2].pcw), 1);
    s = exp_q.size();
    instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 4'b0110, 1'b1, 0);
    pin("bne_pcw", int'(exp_q[s+2].pcw), 0);
    instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 4'b0110, 1'b0, 0);
    instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 4'b0110, 1'b0, 0);
    instr("blt_z1", 7'b1100011, 3'b100, 1'b0, 4'b0110, 1'b1, 0);
    instr("jal", 7'b1101111, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    instr("jalr", 7'b1100111, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    instr("lui", 7'b0110111, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    instr("auipc", 7'b0010111, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    s = exp_q.size();
    instr("illegal", 7'b1111111, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    pin("ill_len", exp_q.size() - s, 2);
    fetch("fetch_timeout", 7'b0110011, 3'b000, 1'b0, TO);
    instr("add_after_ft", 7'b0110011, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    s = exp_q.size();
    instr("sw_timeout", 7'b0100011, 3'b010, 1'b0, 4'b0010, 1'b0, TO);
    pin("swto_len", exp_q.size() - s, 7);
    pin("swto_berr", int'(exp_q[s+6].berr), 1);
    fetch("lw_rst", 7'b0000011, 3'b010, 1'b0, 0);
    decode("lw_rst", 7'b0000011, 3'b010, 1'b0, 1'b0);
    ma("lw_rst", 7'b0000011, 3'b010, 3'b001);
    mem("lw_rst", 7'b0000011, 3'b010, S_MRD, 2, 1'b0);
    rst_cyc("rst_mid_mrd");
    rst_cyc("rst_mid_mrd");
    instr("add_after_rst", 7'b0110011, 3'b000, 1'b0, 4'b0010, 1'b0, 0);
    #2 rst = 1'b1;
    for (int i = 0; i < in_q.size(); i++) begin
      @(posedge clk);
      #1;
      {OPcode, Fun3, Fun7, Zero, MIO_ready, rst} = in_q[i];
      cur = exp_q[i];
      cur_n = nm_q[i];
      chk = 1'b1;
    end
    @(negedge clk);
    #1 chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
